// File: rtl/butterfly_pkg.sv
// Shared widths and the saturation helper for the radix-2 butterfly.
// Imported by butterfly_unit and complex_mult.
package butterfly_pkg;

    localparam int IN_W_DEF   = 8;
    localparam int OUT_W_DEF  = 16;
    localparam int PROD_W_DEF = 2 * IN_W_DEF + 1;
    localparam int SUM_W_DEF  = 2 * IN_W_DEF + 2;
    localparam int SAT_W      = 64;

    // Clamp a wide signed value into the signed range of ow bits.
    function automatic logic signed [SAT_W-1:0] sat_clamp(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             ow
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) begin
            sat_clamp = hi;
        end else if (v < lo) begin
            sat_clamp = lo;
        end else begin
            sat_clamp = v;
        end
    endfunction

endpackage

// File: rtl/butterfly_unit_complex_mult.sv
// Registered full-precision complex multiply T = B * W.
// Result width 2*IN_W+1 holds every product sum without loss.
module complex_mult
    import butterfly_pkg::*;
#(
    parameter int IN_W = IN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic signed [IN_W-1:0] b_re_i,
    input  logic signed [IN_W-1:0] b_im_i,
    input  logic signed [IN_W-1:0] w_re_i,
    input  logic signed [IN_W-1:0] w_im_i,
    output logic signed [2*IN_W:0] t_re_o,
    output logic signed [2*IN_W:0] t_im_o
);

    localparam int PW = 2 * IN_W + 1;

    logic signed [PW-1:0] br, bm, wr, wm;
    logic signed [PW-1:0] t_re_d, t_im_d;
    logic signed [PW-1:0] t_re_q, t_im_q;

    // Widen operands first so products and sums stay exact.
    always_comb begin
        br     = PW'(b_re_i);
        bm     = PW'(b_im_i);
        wr     = PW'(w_re_i);
        wm     = PW'(w_im_i);
        t_re_d = br * wr - bm * wm;
        t_im_d = br * wm + bm * wr;
    end

    // Product register, loads only for a valid operand set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_re_q <= '0;
            t_im_q <= '0;
        end else if (en_i) begin
            t_re_q <= t_re_d;
            t_im_q <= t_im_d;
        end
    end

    assign t_re_o = t_re_q;
    assign t_im_o = t_im_q;

endmodule

// File: rtl/butterfly_unit.sv
// Three-stage radix-2 butterfly: X = A + B*W, Y = A - B*W.
// Outputs saturate to OUT_W; data registers hold when not valid.
module butterfly_unit
    import butterfly_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_valid_in,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  a_q,
    input  logic signed [IN_W-1:0]  b_i,
    input  logic signed [IN_W-1:0]  b_q,
    input  logic signed [IN_W-1:0]  w_i,
    input  logic signed [IN_W-1:0]  w_q,
    output logic signed [OUT_W-1:0] x_i,
    output logic signed [OUT_W-1:0] x_q,
    output logic signed [OUT_W-1:0] y_i,
    output logic signed [OUT_W-1:0] y_q,
    output logic                    data_valid_out
);

    localparam int PW = 2 * IN_W + 1;
    localparam int SW = 2 * IN_W + 2;

    logic [2:0] v_q;

    logic signed [IN_W-1:0] a1i_q, a1q_q, b1i_q, b1q_q, w1i_q, w1q_q;
    logic signed [IN_W-1:0] a2i_q, a2q_q;
    logic signed [PW-1:0]   t_re, t_im;

    logic signed [SW-1:0]   ae_i, ae_q, te_i, te_q;
    logic signed [OUT_W-1:0] xi_d, xq_d, yi_d, yq_d;
    logic signed [OUT_W-1:0] xi_q, xq_q, yi_q, yq_q;

    // Valid shift register, advances every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= {v_q[1:0], data_valid_in};
        end
    end

    // Stage 1: capture the operand set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1i_q <= '0;
            a1q_q <= '0;
            b1i_q <= '0;
            b1q_q <= '0;
            w1i_q <= '0;
            w1q_q <= '0;
        end else if (data_valid_in) begin
            a1i_q <= a_i;
            a1q_q <= a_q;
            b1i_q <= b_i;
            b1q_q <= b_q;
            w1i_q <= w_i;
            w1q_q <= w_q;
        end
    end

    // Stage 2: delay A alongside the product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a2i_q <= '0;
            a2q_q <= '0;
        end else if (v_q[0]) begin
            a2i_q <= a1i_q;
            a2q_q <= a1q_q;
        end
    end

    complex_mult #(
        .IN_W(IN_W)
    ) u_cmul (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (v_q[0]),
        .b_re_i (b1i_q),
        .b_im_i (b1q_q),
        .w_re_i (w1i_q),
        .w_im_i (w1q_q),
        .t_re_o (t_re),
        .t_im_o (t_im)
    );

    // Full-width add/subtract, then clamp to the output range.
    always_comb begin
        ae_i = SW'(a2i_q);
        ae_q = SW'(a2q_q);
        te_i = SW'(t_re);
        te_q = SW'(t_im);
        xi_d = OUT_W'(sat_clamp(SAT_W'(ae_i + te_i), OUT_W));
        xq_d = OUT_W'(sat_clamp(SAT_W'(ae_q + te_q), OUT_W));
        yi_d = OUT_W'(sat_clamp(SAT_W'(ae_i - te_i), OUT_W));
        yq_d = OUT_W'(sat_clamp(SAT_W'(ae_q - te_q), OUT_W));
    end

    // Stage 3: result register, holds the last valid result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xi_q <= '0;
            xq_q <= '0;
            yi_q <= '0;
            yq_q <= '0;
        end else if (v_q[1]) begin
            xi_q <= xi_d;
            xq_q <= xq_d;
            yi_q <= yi_d;
            yq_q <= yq_d;
        end
    end

    assign x_i            = xi_q;
    assign x_q            = xq_q;
    assign y_i            = yi_q;
    assign y_q            = yq_q;
    assign data_valid_out = v_q[2];

endmodule

// File: tb/tb_butterfly_unit.sv
// Directed scoreboard bench for butterfly_unit.
// A second instance with OUT_W=12 exercises saturation.
module tb_butterfly_unit;

    localparam int IW  = 8;
    localparam int OW  = 16;
    localparam int OWS = 12;

    typedef struct {
        int xi;
        int xq;
        int yi;
        int yq;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic data_valid_in;
    logic signed [IW-1:0]  a_i, a_q, b_i, b_q, w_i, w_q;
    logic signed [OW-1:0]  x_i, x_q, y_i, y_q;
    logic signed [OWS-1:0] s_x_i, s_x_q, s_y_i, s_y_q;
    logic dvo, s_dvo;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q[$];
    exp_t last = '{0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    butterfly_unit #(.IN_W(IW), .OUT_W(OW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_valid_in  (data_valid_in),
        .a_i            (a_i),
        .a_q            (a_q),
        .b_i            (b_i),
        .b_q            (b_q),
        .w_i            (w_i),
        .w_q            (w_q),
        .x_i            (x_i),
        .x_q            (x_q),
        .y_i            (y_i),
        .y_q            (y_q),
        .data_valid_out (dvo)
    );

    butterfly_unit #(.IN_W(IW), .OUT_W(OWS)) dut_s (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_valid_in  (data_valid_in),
        .a_i            (a_i),
        .a_q            (a_q),
        .b_i            (b_i),
        .b_q            (b_q),
        .w_i            (w_i),
        .w_q            (w_q),
        .x_i            (s_x_i),
        .x_q            (s_x_q),
        .y_i            (s_y_i),
        .y_q            (s_y_q),
        .data_valid_out (s_dvo)
    );

    function automatic int satw(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exv);
        n_assert++;
        assert (obs === exv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exv);
        end
    endtask

    task automatic chk_vals(input string tag, input exp_t e);
        chk({tag, "_xi"}, x_i, satw(e.xi, OW));
        chk({tag, "_xq"}, x_q, satw(e.xq, OW));
        chk({tag, "_yi"}, y_i, satw(e.yi, OW));
        chk({tag, "_yq"}, y_q, satw(e.yq, OW));
        chk({tag, "_s_xi"}, s_x_i, satw(e.xi, OWS));
        chk({tag, "_s_xq"}, s_x_q, satw(e.xq, OWS));
        chk({tag, "_s_yi"}, s_y_i, satw(e.yi, OWS));
        chk({tag, "_s_yq"}, s_y_q, satw(e.yq, OWS));
    endtask

    // Scoreboard: every output pulse pops one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (dvo || s_dvo)) begin
            chk("dvo_pair", {dvo, s_dvo}, 2'b11);
            if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("latency", cyc - e.cyc, 3);
                chk_vals("out", e);
                last = e;
            end
        end
    end

    task automatic apply(input int ai, input int aq, input int bi,
                         input int bq, input int wi, input int wq);
        exp_t e;
        int ti, tq;
        a_i = IW'(ai);
        a_q = IW'(aq);
        b_i = IW'(bi);
        b_q = IW'(bq);
        w_i = IW'(wi);
        w_q = IW'(wq);
        data_valid_in = 1'b1;
        ti = bi * wi - bq * wq;
        tq = bi * wq + bq * wi;
        e.xi = ai + ti;
        e.xq = aq + tq;
        e.yi = ai - ti;
        e.yq = aq - tq;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic drive(input int ai, input int aq, input int bi,
                         input int bq, input int wi, input int wq);
        @(posedge clk);
        #1;
        apply(ai, aq, bi, bq, wi, wq);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        data_valid_in = 1'b0;
        a_i = IW'($urandom);
        a_q = IW'($urandom);
        b_i = IW'($urandom);
        b_q = IW'($urandom);
        w_i = IW'($urandom);
        w_q = IW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    task automatic hold_chk(input string tag);
        @(negedge clk);
        chk({tag, "_dvo"}, dvo, 0);
        chk_vals(tag, last);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        data_valid_in = 1'b0;
        {a_i, a_q, b_i, b_q, w_i, w_q} = '0;
        repeat (2) @(posedge clk);
        hold_chk("reset");
        rst_n = 1'b1;

        drive(10, 20, 30, 40, 50, 0);
        idle();
        drain();
        repeat (3) hold_chk("hold1");

        drive(0, 0, 3, 4, 0, 1);
        idle();
        drain();

        drive(127, 127, -128, -128, -128, 127);
        drive(-128, -128, -128, -128, 127, -128);
        drive(5, -7, 100, -50, -3, 9);
        drive(-1, 1, 127, 127, 127, 127);
        idle();
        drain();

        for (int i = 0; i < 6; i++) begin
            idle();
            hold_chk("idle_toggle");
        end

        drive(11, 22, 33, 44, 55, 66);
        @(posedge clk);
        #1;
        data_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        last = '{0, 0, 0, 0, 0};
        chk("rst_async_dvo", dvo, 0);
        chk_vals("rst_async", last);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) hold_chk("post_rst");

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(-20, 7, 9, -9, 12, 4);
        @(posedge clk);
        #1;
        data_valid_in = 1'b0;
        drain();
        hold_chk("first_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
